// File: rtl/interact_pkg.sv
// interact_pkg: shared mode, key, direction encodings for the 2048 interaction controller.
package interact_pkg;
   typedef enum logic [3:0] {
      M_IDLE  = 4'd0,
      M_PLAY  = 4'd1,
      M_PAUSE = 4'd2,
      M_WIN   = 4'd3,
      M_OVER  = 4'd4
   } mode_t;
   typedef enum logic [1:0] {D_UP = 2'd0, D_DOWN = 2'd1, D_LEFT = 2'd2, D_RIGHT = 2'd3} dir_t;
   localparam int K_UP      = 0;
   localparam int K_DOWN    = 1;
   localparam int K_LEFT    = 2;
   localparam int K_RIGHT   = 3;
   localparam int K_START   = 4;
   localparam int K_SELECT  = 5;
   localparam int K_PAUSE   = 6;
   localparam int K_RESTART = 7;
   localparam int WIN_EXP_DEF = 11;
endpackage

// File: rtl/interact_if.sv
// interact_if: key bank and board inputs plus mode/board/move outputs of interact_ctrl.
interface interact_if #(
   parameter int N_BOARDS = 2,
   parameter int CELLS    = 16,
   parameter int CELL_W   = 4,
   parameter int SEL_W    = (N_BOARDS > 1) ? $clog2(N_BOARDS) : 1
);
   logic [7:0]                       key;
   logic [N_BOARDS*CELLS*CELL_W-1:0] boards;
   logic [N_BOARDS*CELLS-1:0]        judges;
   logic [3:0]                       mode;
   logic [SEL_W-1:0]                 sel;
   logic [CELLS*CELL_W-1:0]          num;
   logic [CELLS-1:0]                 judge;
   logic                             move_vld;
   logic [1:0]                       move_dir;
   logic                             new_game;
   modport master (output key, boards, judges,
                   input  mode, sel, num, judge, move_vld, move_dir, new_game);
   modport slave  (input  key, boards, judges,
                   output mode, sel, num, judge, move_vld, move_dir, new_game);
endinterface

// File: rtl/key_debounce.sv
// key_debounce: 2-flop synchroniser plus counter debounce; pulses press on an accepted 0->1 flip.
module key_debounce #(
   parameter int DEB_CYC = 20000
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level,
   output logic press
);
   localparam int CNT_W = $clog2(DEB_CYC);
   logic             r_s1, r_s2, r_lvl, r_press;
   logic [CNT_W-1:0] r_cnt;
   logic             w_flip;
   assign w_flip = (r_s2 != r_lvl) && (r_cnt == CNT_W'(DEB_CYC - 1));
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1    <= 1'b0;
         r_s2    <= 1'b0;
         r_lvl   <= 1'b0;
         r_press <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_s1    <= raw;
         r_s2    <= r_s1;
         r_cnt   <= (r_s2 == r_lvl || w_flip) ? '0 : r_cnt + CNT_W'(1);
         r_lvl   <= w_flip ? r_s2 : r_lvl;
         r_press <= w_flip & r_s2;
      end
   end
   assign level = r_lvl;
   assign press = r_press;
endmodule

// File: rtl/interact_ctrl.sv
// interact_ctrl: debounced key events drive the game-mode FSM, board select and move requests.
module interact_ctrl
   import interact_pkg::*;
#(
   parameter int N_BOARDS = 2,
   parameter int CELLS    = 16,
   parameter int CELL_W   = 4,
   parameter int WIN_EXP  = WIN_EXP_DEF,
   parameter int DEB_CYC  = 20000
) (
   input logic       clk,
   input logic       rst,
   interact_if.slave io_bus
);
   localparam int SEL_W = (N_BOARDS > 1) ? $clog2(N_BOARDS) : 1;
   localparam int BW    = CELLS * CELL_W;
   logic [7:0]       w_lvl, w_press;
   mode_t            r_mode, w_mode_nxt;
   logic [SEL_W-1:0] r_sel, w_sel_nxt;
   logic [BW-1:0]    r_num;
   logic [CELLS-1:0] r_judge;
   logic             r_move_vld, r_new_game;
   dir_t             r_move_dir, w_dir;
   logic             w_restart, w_sp, w_select, w_dir_ev, w_win, w_over, w_move;
   for (genvar g = 0; g < 8; g++) begin : g_deb
      key_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
         .clk  (clk),
         .rst  (rst),
         .raw  (io_bus.key[g]),
         .level(w_lvl[g]),
         .press(w_press[g])
      );
   end
   always_comb begin
      w_restart = w_press[K_RESTART];
      w_sp      = ~w_restart & (w_press[K_START] | w_press[K_PAUSE]);
      w_select  = ~w_restart & ~w_sp & w_press[K_SELECT];
      w_dir_ev  = ~w_restart & ~w_sp & ~w_press[K_SELECT] & (|w_press[K_RIGHT:K_UP]);
      w_dir     = w_press[K_UP] ? D_UP : w_press[K_DOWN] ? D_DOWN : w_press[K_LEFT] ? D_LEFT : D_RIGHT;
      w_win     = 1'b0;
      for (int i = 0; i < CELLS; i++)
         if (r_num[i*CELL_W +: CELL_W] == CELL_W'(WIN_EXP)) w_win = 1'b1;
      w_over     = ~|r_judge;
      w_mode_nxt = r_mode;
      if (w_restart) w_mode_nxt = M_IDLE;
      else
         case (r_mode)
            M_IDLE:  w_mode_nxt = (w_sp & w_press[K_START]) ? M_PLAY : M_IDLE;
            M_PLAY:  w_mode_nxt = w_win ? M_WIN : w_over ? M_OVER : (w_sp & w_press[K_PAUSE]) ? M_PAUSE : M_PLAY;
            M_PAUSE: w_mode_nxt = w_sp ? M_PLAY : M_PAUSE;
            default: w_mode_nxt = r_mode;
         endcase
      w_move    = w_dir_ev && r_mode == M_PLAY && w_mode_nxt == M_PLAY;
      w_sel_nxt = (w_select && (r_mode == M_IDLE || r_mode == M_PAUSE))
                ? ((r_sel == SEL_W'(N_BOARDS - 1)) ? '0 : r_sel + SEL_W'(1)) : r_sel;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_mode     <= M_IDLE;
         r_sel      <= '0;
         r_num      <= '0;
         r_judge    <= '0;
         r_move_vld <= 1'b0;
         r_move_dir <= D_UP;
         r_new_game <= 1'b0;
      end else begin
         r_mode     <= w_mode_nxt;
         r_sel      <= w_sel_nxt;
         r_num      <= io_bus.boards[r_sel*BW +: BW];
         r_judge    <= io_bus.judges[r_sel*CELLS +: CELLS];
         r_move_vld <= w_move;
         r_move_dir <= w_move ? w_dir : r_move_dir;
         r_new_game <= w_restart;
      end
   end
   assign io_bus.mode     = r_mode;
   assign io_bus.sel      = r_sel;
   assign io_bus.num      = r_num;
   assign io_bus.judge    = r_judge;
   assign io_bus.move_vld = r_move_vld;
   assign io_bus.move_dir = r_move_dir;
   assign io_bus.new_game = r_new_game;
endmodule
